// File: rtl/cpu_cmd_sequencer.sv
// cpu_cmd_sequencer: accepts packed STORE/ADD/SUB/READ commands, drives the
// cpu control/address ports with a control word held for HOLD_CYCLES clocks,
// samples the cpu result and returns it over a valid/ready response channel.
// One command is in flight at a time; all outputs are registered.

module cpu_cmd_sequencer #(
  parameter int HOLD_CYCLES = 2,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [4:0]       cmd_addr_a,
  input  logic [4:0]       cmd_addr_b,
  input  logic [31:0]      cmd_data,
  output logic [4:0]       addressA,
  output logic [4:0]       addressB,
  output logic [31:0]      dataIn,
  output logic             asel,
  output logic             bsel,
  output logic [1:0]       opsel,
  output logic [1:0]       outsel,
  output logic             oen,
  input  logic [31:0]      cpu_out,
  input  logic             cpu_over,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_data,
  output logic             rsp_over,
  output logic             rsp_err,
  output logic [CNT_W-1:0] cmd_count,
  output logic [CNT_W-1:0] ovf_count
);

  // Hold counter only needs to reach HOLD_CYCLES-1.
  localparam int HCW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HCW-1:0] HOLD_LAST = HCW'(HOLD_CYCLES - 1);

  localparam logic [2:0] OP_STORE = 3'd0;
  localparam logic [2:0] OP_ADD   = 3'd1;
  localparam logic [2:0] OP_SUB   = 3'd2;
  localparam logic [2:0] OP_READ  = 3'd3;

  // Control word packing: {asel, bsel, opsel[1:0], outsel[1:0], oen}
  localparam logic [6:0] CW_STORE = 7'b0_0_01_00_1;
  localparam logic [6:0] CW_ADD   = 7'b1_1_00_01_1;
  localparam logic [6:0] CW_SUB   = 7'b1_1_01_01_1;
  localparam logic [6:0] CW_READ  = 7'b1_0_01_00_1;
  localparam logic [6:0] CW_IDLE  = 7'b1_0_01_00_0;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RESP  = 2'd2
  } state_t;

  // Map a legal opcode onto its cpu control word; anything else is non-writing.
  function automatic logic [6:0] ctrl_word(input logic [2:0] op);
    logic [6:0] w;
    case (op)
      OP_STORE: w = CW_STORE;
      OP_ADD:   w = CW_ADD;
      OP_SUB:   w = CW_SUB;
      OP_READ:  w = CW_READ;
      default:  w = CW_IDLE;
    endcase
    return w;
  endfunction

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] r;
    if (v == CNT_MAX) begin
      r = v;
    end else begin
      r = v + CNT_W'(1);
    end
    return r;
  endfunction

  state_t           state_q,     state_d;
  logic [2:0]       op_q,        op_d;
  logic [HCW-1:0]   hold_cnt_q,  hold_cnt_d;
  logic             cmd_ready_q, cmd_ready_d;
  logic [6:0]       ctrl_q,      ctrl_d;
  logic [4:0]       addr_a_q,    addr_a_d;
  logic [4:0]       addr_b_q,    addr_b_d;
  logic [31:0]      data_in_q,   data_in_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [31:0]      rsp_data_q,  rsp_data_d;
  logic             rsp_over_q,  rsp_over_d;
  logic             rsp_err_q,   rsp_err_d;
  logic [CNT_W-1:0] cmd_cnt_q,   cmd_cnt_d;
  logic [CNT_W-1:0] ovf_cnt_q,   ovf_cnt_d;

  // Next-state and next-output logic for the IDLE/ISSUE/RESP sequencer.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    hold_cnt_d  = hold_cnt_q;
    cmd_ready_d = cmd_ready_q;
    ctrl_d      = ctrl_q;
    addr_a_d    = addr_a_q;
    addr_b_d    = addr_b_q;
    data_in_d   = data_in_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_over_d  = rsp_over_q;
    rsp_err_d   = rsp_err_q;
    cmd_cnt_d   = cmd_cnt_q;
    ovf_cnt_d   = ovf_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          cmd_ready_d = 1'b0;
          if (cmd_op <= OP_READ) begin
            // Legal: the port registers double as the latched command fields.
            state_d    = S_ISSUE;
            op_d       = cmd_op;
            hold_cnt_d = '0;
            ctrl_d     = ctrl_word(cmd_op);
            addr_a_d   = cmd_addr_a;
            addr_b_d   = cmd_addr_b;
            if (cmd_op == OP_STORE) begin
              data_in_d = cmd_data;
            end else begin
              data_in_d = 32'd0;
            end
          end else begin
            // Illegal: answer immediately, cpu ports stay at the idle word.
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_data_d  = 32'd0;
            rsp_over_d  = 1'b0;
          end
        end else begin
          cmd_ready_d = 1'b1;
        end
      end

      S_ISSUE: begin
        if (hold_cnt_q == HOLD_LAST) begin
          // Last held cycle: sample the cpu and drop back to the idle word.
          state_d     = S_RESP;
          ctrl_d      = CW_IDLE;
          addr_a_d    = 5'd0;
          addr_b_d    = 5'd0;
          data_in_d   = 32'd0;
          rsp_valid_d = 1'b1;
          rsp_data_d  = cpu_out;
          rsp_err_d   = 1'b0;
          if ((op_q == OP_ADD) || (op_q == OP_SUB)) begin
            rsp_over_d = cpu_over;
          end else begin
            rsp_over_d = 1'b0;
          end
        end else begin
          hold_cnt_d = hold_cnt_q + HCW'(1);
        end
      end

      S_RESP: begin
        if (rsp_ready) begin
          state_d     = S_IDLE;
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          if (!rsp_err_q) begin
            cmd_cnt_d = sat_inc(cmd_cnt_q);
          end else begin
            cmd_cnt_d = cmd_cnt_q;
          end
          if (rsp_over_q) begin
            ovf_cnt_d = sat_inc(ovf_cnt_q);
          end else begin
            ovf_cnt_d = ovf_cnt_q;
          end
        end else begin
          state_d = S_RESP;
        end
      end

      default: begin
        state_d     = S_IDLE;
        cmd_ready_d = 1'b0;
        ctrl_d      = CW_IDLE;
        addr_a_d    = 5'd0;
        addr_b_d    = 5'd0;
        data_in_d   = 32'd0;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers; synchronous reset aborts any in-flight command.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      op_q        <= OP_STORE;
      hold_cnt_q  <= '0;
      cmd_ready_q <= 1'b0;
      ctrl_q      <= CW_IDLE;
      addr_a_q    <= 5'd0;
      addr_b_q    <= 5'd0;
      data_in_q   <= 32'd0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 32'd0;
      rsp_over_q  <= 1'b0;
      rsp_err_q   <= 1'b0;
      cmd_cnt_q   <= '0;
      ovf_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      hold_cnt_q  <= hold_cnt_d;
      cmd_ready_q <= cmd_ready_d;
      ctrl_q      <= ctrl_d;
      addr_a_q    <= addr_a_d;
      addr_b_q    <= addr_b_d;
      data_in_q   <= data_in_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_over_q  <= rsp_over_d;
      rsp_err_q   <= rsp_err_d;
      cmd_cnt_q   <= cmd_cnt_d;
      ovf_cnt_q   <= ovf_cnt_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign addressA  = addr_a_q;
  assign addressB  = addr_b_q;
  assign dataIn    = data_in_q;
  assign asel      = ctrl_q[6];
  assign bsel      = ctrl_q[5];
  assign opsel     = ctrl_q[4:3];
  assign outsel    = ctrl_q[2:1];
  assign oen       = ctrl_q[0];
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_over  = rsp_over_q;
  assign rsp_err   = rsp_err_q;
  assign cmd_count = cmd_cnt_q;
  assign ovf_count = ovf_cnt_q;

endmodule

// File: tb/tb_cpu_cmd_sequencer.sv
// Bench for cpu_cmd_sequencer: a behavioural cpu register file/ALU model,
// a vector table replayed through a command task, a response scoreboard,
// and hand-written reset/saturation sequences.

module tb_cpu_cmd_sequencer;

  localparam int HOLD = 2;
  localparam int CW   = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready;
  logic [2:0]  cmd_op;
  logic [4:0]  cmd_addr_a, cmd_addr_b;
  logic [31:0] cmd_data;
  logic [4:0]  addressA, addressB;
  logic [31:0] dataIn;
  logic        asel, bsel, oen;
  logic [1:0]  opsel, outsel;
  logic [31:0] cpu_out;
  logic        cpu_over;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_over, rsp_err;
  logic [CW-1:0] cmd_count, ovf_count;

  cpu_cmd_sequencer #(.HOLD_CYCLES(HOLD), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr_a(cmd_addr_a), .cmd_addr_b(cmd_addr_b), .cmd_data(cmd_data),
    .addressA(addressA), .addressB(addressB), .dataIn(dataIn),
    .asel(asel), .bsel(bsel), .opsel(opsel), .outsel(outsel), .oen(oen),
    .cpu_out(cpu_out), .cpu_over(cpu_over),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_over(rsp_over), .rsp_err(rsp_err),
    .cmd_count(cmd_count), .ovf_count(ovf_count)
  );

  always #5 clk = ~clk;

  // ---------------- cpu model ----------------
  // Operands read the register file; the write is committed once oen drops,
  // so the result stays stable across the whole hold window.
  logic [31:0] rf [32];
  logic [31:0] a_v, b_v, alu_v;
  logic        ovf_v;
  logic        wr_pend;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;

  always_comb begin
    a_v = asel ? rf[addressA] : dataIn;
    b_v = bsel ? rf[addressB] : 32'd0;
    if (opsel == 2'b00) begin
      alu_v = a_v + b_v;
      ovf_v = (a_v[31] == b_v[31]) && (alu_v[31] != a_v[31]);
    end else begin
      alu_v = a_v - b_v;
      ovf_v = (a_v[31] != b_v[31]) && (alu_v[31] != a_v[31]);
    end
    cpu_out  = (outsel == 2'b01) ? alu_v : a_v;
    cpu_over = ovf_v;
  end

  always @(posedge clk) begin
    if (rst) begin
      wr_pend <= 1'b0;
    end else if (oen) begin
      wr_pend <= 1'b1;
      wr_addr <= addressB;
      wr_data <= cpu_out;
    end else if (wr_pend) begin
      rf[wr_addr] <= wr_data;
      wr_pend     <= 1'b0;
    end
  end

  // ---------------- checking ----------------
  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] d;
    logic        o;
    logic        e;
  } rsp_t;
  rsp_t sbq[$];

  logic [CW-1:0] exp_cmd, exp_ovf;

  localparam logic [16:0] IDLE_PORTS = {5'd0, 5'd0, 7'b1_0_01_00_0};

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] exp_word(input logic [2:0] op);
    case (op)
      3'd0:    return 7'b0_0_01_00_1;
      3'd1:    return 7'b1_1_00_01_1;
      3'd2:    return 7'b1_1_01_01_1;
      3'd3:    return 7'b1_0_01_00_1;
      default: return 7'b1_0_01_00_0;
    endcase
  endfunction

  function automatic logic [16:0] ports_now();
    return {addressA, addressB, asel, bsel, opsel, outsel, oen};
  endfunction

  function automatic logic [CW-1:0] sat(input logic [CW-1:0] v);
    return (v == {CW{1'b1}}) ? v : v + CW'(1);
  endfunction

  // Issue one command, check held ports, latency, backpressure and response.
  task automatic do_cmd(input logic [2:0] op, input logic [4:0] a, input logic [4:0] b,
                        input logic [31:0] d, input logic [31:0] ed, input logic eo,
                        input logic ee, input int stall);
    rsp_t er, got;
    int   n;
    er.d = ed; er.o = eo; er.e = ee;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_addr_a = a; cmd_addr_b = b; cmd_data = d;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("cmd_ready_wait", 64'(cmd_ready), 64'(1'b1));
    if (cmd_ready !== 1'b1) begin
      cmd_valid = 1'b0;
      return;
    end
    sbq.push_back(er);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0; cmd_op = 3'd2; cmd_addr_a = 5'd31; cmd_addr_b = 5'd31;
    cmd_data = 32'hA5A5_5A5A;
    if (op <= 3'd3) begin
      for (int k = 0; k < HOLD; k++) begin
        @(negedge clk);
        chk("held_ports", 64'(ports_now()), 64'({a, b, exp_word(op)}));
        chk("ready_in_issue", 64'(cmd_ready), 64'(1'b0));
        chk("valid_in_issue", 64'(rsp_valid), 64'(1'b0));
        if (op == 3'd0) chk("store_data", 64'(dataIn), 64'(d));
      end
    end
    @(negedge clk);
    chk("rsp_latency", 64'(rsp_valid), 64'(1'b1));
    chk("ports_idle", 64'({ports_now(), dataIn}), 64'({IDLE_PORTS, 32'd0}));
    rsp_ready = (stall == 0);
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      chk("stall_valid", 64'(rsp_valid), 64'(1'b1));
      chk("stall_data", 64'(rsp_data), 64'(ed));
      chk("stall_ready", 64'(cmd_ready), 64'(1'b0));
      chk("stall_ports", 64'(ports_now()), 64'(IDLE_PORTS));
    end
    rsp_ready = 1'b1;
    if (sbq.size() == 0) begin
      chk("sb_empty", 64'(0), 64'(1));
    end else begin
      got = sbq.pop_front();
      chk("rsp_data", 64'(rsp_data), 64'(got.d));
      chk("rsp_over", 64'(rsp_over), 64'(got.o));
      chk("rsp_err", 64'(rsp_err), 64'(got.e));
      if (!got.e) exp_cmd = sat(exp_cmd);
      if (got.o)  exp_ovf = sat(exp_ovf);
    end
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    chk("ready_after_rsp", 64'(cmd_ready), 64'(1'b1));
    chk("valid_dropped", 64'(rsp_valid), 64'(1'b0));
    chk("cmd_count", 64'(cmd_count), 64'(exp_cmd));
    chk("ovf_count", 64'(ovf_count), 64'(exp_ovf));
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [4:0]  a;
    logic [4:0]  b;
    logic [31:0] d;
    logic [31:0] ed;
    logic        eo;
    logic        ee;
    int          stall;
  } vec_t;
  vec_t vt[16];

  initial begin
    vt[0]  = '{3'd0, 5'd0,  5'd0,  32'hFFFF_FFEF, 32'hFFFF_FFEF, 1'b0, 1'b0, 0};
    vt[1]  = '{3'd0, 5'd0,  5'd1,  32'h0000_0011, 32'h0000_0011, 1'b0, 1'b0, 0};
    vt[2]  = '{3'd0, 5'd0,  5'd2,  32'h0000_0022, 32'h0000_0022, 1'b0, 1'b0, 0};
    vt[3]  = '{3'd0, 5'd0,  5'd22, 32'h0000_0044, 32'h0000_0044, 1'b0, 1'b0, 0};
    vt[4]  = '{3'd1, 5'd0,  5'd1,  32'd0,         32'h0000_0000, 1'b0, 1'b0, 0};
    vt[5]  = '{3'd3, 5'd1,  5'd1,  32'd0,         32'h0000_0000, 1'b0, 1'b0, 0};
    vt[6]  = '{3'd1, 5'd1,  5'd2,  32'd0,         32'h0000_0022, 1'b0, 1'b0, 0};
    vt[7]  = '{3'd2, 5'd0,  5'd22, 32'd0,         32'hFFFF_FFAB, 1'b0, 1'b0, 0};
    vt[8]  = '{3'd3, 5'd22, 5'd22, 32'd0,         32'hFFFF_FFAB, 1'b0, 1'b0, 0};
    vt[9]  = '{3'd0, 5'd0,  5'd3,  32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0, 1'b0, 0};
    vt[10] = '{3'd0, 5'd0,  5'd4,  32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0, 0};
    vt[11] = '{3'd1, 5'd3,  5'd4,  32'd0,         32'h8000_0000, 1'b1, 1'b0, 0};
    vt[12] = '{3'd3, 5'd3,  5'd3,  32'd0,         32'h7FFF_FFFF, 1'b0, 1'b0, 0};
    vt[13] = '{3'd2, 5'd4,  5'd3,  32'd0,         32'h0000_0001, 1'b1, 1'b0, 0};
    vt[14] = '{3'd3, 5'd3,  5'd3,  32'd0,         32'h0000_0001, 1'b0, 1'b0, 5};
    vt[15] = '{3'd5, 5'd7,  5'd7,  32'h0000_DEAD, 32'h0000_0000, 1'b0, 1'b1, 0};

    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_addr_a = 5'd0;
    cmd_addr_b = 5'd0; cmd_data = 32'd0; rsp_ready = 1'b0;
    exp_cmd = '0; exp_ovf = '0;

    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst_cmd_ready", 64'(cmd_ready), 64'(1'b0));
    chk("rst_ports", 64'({ports_now(), dataIn}), 64'({IDLE_PORTS, 32'd0}));
    chk("rst_rsp", 64'({rsp_valid, rsp_over, rsp_err, rsp_data}), 64'(0));
    chk("rst_counts", 64'({cmd_count, ovf_count}), 64'(0));
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", 64'(cmd_ready), 64'(1'b1));

    // Vector table: stores, arithmetic, overflow, backpressure, illegal op.
    for (int i = 0; i < 16; i++) begin
      do_cmd(vt[i].op, vt[i].a, vt[i].b, vt[i].d, vt[i].ed, vt[i].eo, vt[i].ee, vt[i].stall);
    end

    // Drive cmd_count into saturation and past it (r3 holds 1).
    while (exp_cmd != {CW{1'b1}}) begin
      do_cmd(3'd3, 5'd3, 5'd3, 32'd0, 32'h0000_0001, 1'b0, 1'b0, 0);
    end
    do_cmd(3'd3, 5'd3, 5'd3, 32'd0, 32'h0000_0001, 1'b0, 1'b0, 0);
    do_cmd(3'd3, 5'd3, 5'd3, 32'd0, 32'h0000_0001, 1'b0, 1'b0, 0);
    chk("count_saturated", 64'(cmd_count), 64'({CW{1'b1}}));

    // Reset during the 2nd ISSUE cycle of a STORE.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 3'd0; cmd_addr_a = 5'd0; cmd_addr_b = 5'd5;
    cmd_data = 32'h0000_0055;
    chk("abort_ready", 64'(cmd_ready), 64'(1'b1));
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("abort_issue1", 64'(ports_now()), 64'({5'd0, 5'd5, 7'b0_0_01_00_1}));
    @(negedge clk);
    chk("abort_issue2", 64'(oen), 64'(1'b1));
    rst = 1'b1;
    @(negedge clk);
    chk("abort_ports", 64'({ports_now(), dataIn}), 64'({IDLE_PORTS, 32'd0}));
    chk("abort_valid", 64'(rsp_valid), 64'(1'b0));
    chk("abort_counts", 64'({cmd_count, ovf_count}), 64'(0));
    chk("abort_ready_low", 64'(cmd_ready), 64'(1'b0));
    rst = 1'b0;
    exp_cmd = '0; exp_ovf = '0;
    @(negedge clk);
    chk("abort_ready_back", 64'(cmd_ready), 64'(1'b1));
    chk("abort_still_idle", 64'(rsp_valid), 64'(1'b0));

    // Sequencer is usable again after the abort.
    do_cmd(3'd0, 5'd0, 5'd6, 32'h0000_0066, 32'h0000_0066, 1'b0, 1'b0, 0);
    chk("sb_drained", 64'(sbq.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #500000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/cpu_cmd_sequencer.md
Name: cpu_cmd_sequencer

Overview:
Command-side driver for the cpu datapath. It accepts packed register-file/ALU commands over a valid/ready interface and drives the cpu control and address ports with correctly held control words. It samples the cpu result and overflow flag and returns them over a valid/ready response interface. It replaces hand-timed stimulus, so software or a test harness can run STORE/ADD/SUB/READ sequences against the cpu.

Parameters:
HOLD_CYCLES, 2, number of clock cycles each control word is held on the cpu ports (min 1)
CNT_W, 8, width of the saturating command and overflow counters

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  synchronous reset, active-high
cmd_valid  input  1  command present
cmd_ready  output  1  sequencer can accept a command
cmd_op  input  3  0=STORE, 1=ADD, 2=SUB, 3=READ; 4-7 illegal
cmd_addr_a  input  5  source register A
cmd_addr_b  input  5  source B / destination register
cmd_data  input  32  STORE data
addressA  output  5  to cpu
addressB  output  5  to cpu
dataIn  output  32  to cpu
asel  output  1  to cpu
bsel  output  1  to cpu
opsel  output  2  to cpu
outsel  output  2  to cpu
oen  output  1  to cpu
cpu_out  input  32  cpu result bus
cpu_over  input  1  cpu overflow flag
rsp_valid  output  1  response present
rsp_ready  input  1  consumer accepts response
rsp_data  output  32  captured cpu_out
rsp_over  output  1  overflow for ADD/SUB, else 0
rsp_err  output  1  illegal opcode; no cpu access made
cmd_count  output  CNT_W  legal commands completed, saturating
ovf_count  output  CNT_W  responses with rsp_over=1, saturating

Behaviour:
- One clock domain. Synchronous active-high rst.
- Control-word encoding {asel,bsel,opsel,outsel,oen}:
  - STORE: 0,0,01,00,1. dataIn=cmd_data, written to addressB.
  - ADD: 1,1,00,01,1. Result of A+B written to addressB.
  - SUB: 1,1,01,01,1. Result of A-B written to addressB.
  - READ: 1,0,01,00,1. Register addressA appears on cpu_out.
  - IDLE (non-writing): 1,0,01,00,0. Addresses 0, dataIn 0.
- Reset values: state IDLE; cpu ports at IDLE word; cmd_ready=0 during rst and 1 in the cycle after; rsp_valid/rsp_over/rsp_err=0; rsp_data=0; counters=0.
- FSM:
  - IDLE: cmd_ready=1. On cmd_valid&cmd_ready:
    - legal op: latch cmd fields, go to ISSUE, hold_cnt=0.
    - illegal op: go to RESP with rsp_err=1, rsp_data=0, rsp_over=0. No cpu ports change.
  - ISSUE: cmd_ready=0. Drive the op's control word and latched addresses/data for exactly HOLD_CYCLES cycles. On the edge ending the last held cycle: rsp_data<=cpu_out; rsp_over<=cpu_over if ADD/SUB else 0; rsp_err<=0; go to RESP. Ports return to the IDLE word that same edge.
  - RESP: rsp_valid=1. rsp_data/rsp_over/rsp_err are stable while rsp_valid&!rsp_ready. On rsp_ready: go to IDLE; cmd_count+1 if !rsp_err; ovf_count+1 if rsp_over; both saturate at all-ones.
- Latency: command accepted at edge N → control on ports cycles N+1..N+HOLD_CYCLES → rsp_valid asserted from cycle N+HOLD_CYCLES+1. Back-to-back throughput is HOLD_CYCLES+2 cycles per command with rsp_ready held high.
- One outstanding command. cmd_ready is never high outside IDLE. Command inputs are ignored outside IDLE.
- rst mid-ISSUE or mid-RESP: abort immediately. Ports return to the IDLE word, response is dropped, counters clear. The partially held cpu write is not retried.
- Counters saturate and never wrap.

Test Plan:
1. STORE 0xFFFFFFEF→r0, 0x11→r1, 0x22→r2, 0x44→r22. Each: asel=bsel=0 held exactly 2 cycles, rsp_err=0, cmd_count=4.
2. After (1): ADD a=0,b=1 → rsp_data=0, rsp_over=0. READ a=1 → 0. ADD a=1,b=2 → 0x22. SUB a=0,b=22 → 0xFFFFFFAB. READ a=22 → 0xFFFFFFAB.
3. STORE 0x7FFFFFFF→r3, 1→r4. ADD a=3,b=4 → rsp_data=0x80000000, rsp_over=1, ovf_count=1. READ a=3 → rsp_over=0.
4. Backpressure: hold rsp_ready=0 for 5 cycles on a READ. rsp_valid and rsp_data stay stable, cmd_ready=0, cpu ports at the IDLE word. Release → cmd_ready=1 on the next cycle.
5. cmd_op=5 → rsp_err=1 one cycle after accept. oen never asserts. cmd_count unchanged.
6. Assert rst during the 2nd ISSUE cycle of a STORE 0x55→r5. Next cycle: IDLE word on ports, rsp_valid=0, counters=0. cmd_ready=1 one cycle after rst deasserts.
